// File: rtl/fc_pkg.sv
// Shared FSM encoding, default datapath widths and the output saturate/shift helper for fc_layer_engine.
package fc_pkg;

  localparam int DATA_W_D = 16;
  localparam int FRAC_W_D = 8;
  localparam int ACC_W_D  = 40;

  typedef enum logic [2:0] {
    ST_CAPTURE = 3'd0,
    ST_MAC     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_OUT     = 3'd3,
    ST_FINISH  = 3'd4
  } fc_state_e;

  localparam logic signed [ACC_W_D-1:0] SAT_MAX = ACC_W_D'((longint'(1) <<< (DATA_W_D - 1)) - longint'(1));
  localparam logic signed [ACC_W_D-1:0] SAT_MIN = ~SAT_MAX;

  // Arithmetic (floor) shift back to DATA_W fraction, then clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W_D-1:0] sat_shift(input logic signed [ACC_W_D-1:0] sum);
    logic signed [ACC_W_D-1:0] sh;
    sh = sum >>> FRAC_W_D;
    if (sh > SAT_MAX) return SAT_MAX[DATA_W_D-1:0];
    if (sh < SAT_MIN) return SAT_MIN[DATA_W_D-1:0];
    return sh[DATA_W_D-1:0];
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed MAC: clear/accumulate h*w into ACC_W, then combinational bias add, floor shift and saturate.
// One product per enabled cycle; res_o reflects the current accumulator with no extra latency.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int FRAC_W = FRAC_W_D,
  parameter int ACC_W  = ACC_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] h_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    sum;

  assign prod     = (2*DATA_W)'(h_i) * (2*DATA_W)'(w_i);
  assign bias_ext = ACC_W'(b_i) <<< FRAC_W;
  assign sum      = acc_q + bias_ext;
  assign res_o    = DATA_W'(sat_shift(ACC_W_D'(sum)));

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// FC output stage: captures the hidden vector, then N+2 cycles per neuron on one MAC; no backpressure.
// Define FC_ARGMAX_EN to drive fc_class with the running argmax (ties keep the lower index).
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int ALL_CELL_NUM = 30,
  parameter int OUT_NUM      = 10,
  parameter int DATA_W       = DATA_W_D,
  parameter int FRAC_W       = FRAC_W_D,
  parameter int ACC_W        = ACC_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     h_to_full_en,
  input  logic [7:0]               to_full_h_addr,
  input  logic signed [DATA_W-1:0] h_in,
  output logic [15:0]              w_rd_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [7:0]               b_rd_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     fc_o_valid,
  output logic signed [DATA_W-1:0] fc_o_data,
  output logic [7:0]               fc_o_idx,
  output logic                     fc_busy,
  output logic                     fc_done,
  output logic [7:0]               fc_class,
  output logic                     cap_ovr
);

  localparam int           AW     = (ALL_CELL_NUM > 1) ? $clog2(ALL_CELL_NUM) : 1;
  localparam logic [7:0]   N_ADDR = 8'(ALL_CELL_NUM);
  localparam logic [7:0]   K_LAST = 8'(ALL_CELL_NUM - 1);
  localparam logic [7:0]   O_LAST = 8'(OUT_NUM - 1);

  fc_state_e                state_q;
  logic [7:0]               o_q, k_q;
  logic [15:0]              w_addr_q;
  logic [7:0]               b_addr_q;
  logic signed [DATA_W-1:0] h_rd_q;
  logic                     mac_en_q;
  logic                     valid_q, busy_q, done_q, ovr_q;
  logic signed [DATA_W-1:0] data_q;
  logic [7:0]               idx_q;
  logic signed [DATA_W-1:0] hbuf_q [ALL_CELL_NUM];
  logic signed [DATA_W-1:0] mac_res;
  logic                     wr_ok;
  logic                     mac_clr;

  assign wr_ok   = h_to_full_en && (to_full_h_addr < N_ADDR);
  assign mac_clr = (state_q == ST_MAC) && (k_q == 8'd0);

  // Hidden buffer carries no reset: only CAPTURE writes reach it and contents before capture are unused.
  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE && wr_ok) begin
      hbuf_q[to_full_h_addr[AW-1:0]] <= h_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CAPTURE;
      o_q      <= '0;
      k_q      <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      h_rd_q   <= '0;
      mac_en_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
    end else begin
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      mac_en_q <= 1'b0;
      if (h_to_full_en && state_q != ST_CAPTURE) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        ST_CAPTURE: begin
          if (wr_ok) begin
            busy_q <= 1'b1;
            if (to_full_h_addr == K_LAST) begin
              state_q  <= ST_MAC;
              o_q      <= '0;
              k_q      <= '0;
              w_addr_q <= '0;
            end
          end
        end
        ST_MAC: begin
          // hbuf read is registered so it lines up with the 1-cycle weight ROM data.
          mac_en_q <= 1'b1;
          h_rd_q   <= hbuf_q[k_q[AW-1:0]];
          if (k_q == K_LAST) begin
            state_q  <= ST_DRAIN;
            b_addr_q <= o_q;
          end else begin
            k_q      <= k_q + 8'd1;
            w_addr_q <= w_addr_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          valid_q <= 1'b1;
          data_q  <= mac_res;
          idx_q   <= o_q;
          if (o_q == O_LAST) begin
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ST_MAC;
            o_q      <= o_q + 8'd1;
            k_q      <= '0;
            w_addr_q <= w_addr_q + 16'd1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_CAPTURE;
        end
        default: begin
          state_q <= ST_CAPTURE;
        end
      endcase
    end
  end

  fc_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en_q),
    .h_i   (h_rd_q),
    .w_i   (w_data),
    .b_i   (b_data),
    .res_o (mac_res)
  );

`ifdef FC_ARGMAX_EN
  logic signed [DATA_W-1:0] max_q;
  logic [7:0]               max_idx_q;
  logic [7:0]               class_q;
  logic                     take_new;

  assign take_new = (o_q == 8'd0) || (mac_res > max_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      max_idx_q <= '0;
      class_q   <= '0;
    end else if (state_q == ST_OUT) begin
      if (take_new) begin
        max_q     <= mac_res;
        max_idx_q <= o_q;
      end
      if (o_q == O_LAST) begin
        class_q <= take_new ? o_q : max_idx_q;
      end
    end
  end

  assign fc_class = class_q;
`else
  assign fc_class = '0;
`endif

  assign w_rd_addr  = w_addr_q;
  assign b_rd_addr  = b_addr_q;
  assign fc_o_valid = valid_q;
  assign fc_o_data  = data_q;
  assign fc_o_idx   = idx_q;
  assign fc_busy    = busy_q;
  assign fc_done    = done_q;
  assign cap_ovr    = ovr_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine: directed frames push expected results, a monitor pops and compares.
module tb_fc_layer_engine;

  localparam int N  = 30;
  localparam int ON = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               h_to_full_en = 1'b0;
  logic [7:0]         to_full_h_addr = 8'd0;
  logic signed [15:0] h_in = 16'sd0;
  logic [15:0]        w_rd_addr;
  logic signed [15:0] w_data = 16'sd0;
  logic [7:0]         b_rd_addr;
  logic signed [15:0] b_data = 16'sd0;
  logic               fc_o_valid;
  logic signed [15:0] fc_o_data;
  logic [7:0]         fc_o_idx;
  logic               fc_busy;
  logic               fc_done;
  logic [7:0]         fc_class;
  logic               cap_ovr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_last = 0;
  int target = 0;
  int exp_cls = 0;

  int h_vec[N];
  int w_rom[N*ON];
  int b_rom[ON];
  int exp_vals[ON];
  int amax_w0[ON]  = '{5, 9, 9, -2, 0, 1, 3, 9, -7, 4};
  int floor_w0[ON] = '{3, -3, 1, -1, 5, -5, 0, 2, -2, 7};
  int floor_ex[ON] = '{1, -2, 0, -1, 2, -3, 0, 1, -1, 3};

  typedef struct {
    int data;
    int idx;
    int cyc;
  } res_t;
  typedef struct {
    int cyc;
    int cls;
  } done_t;

  res_t  exp_q[$];
  done_t done_q[$];
  res_t  mon_r;
  done_t mon_d;

  fc_layer_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .h_to_full_en   (h_to_full_en),
    .to_full_h_addr (to_full_h_addr),
    .h_in           (h_in),
    .w_rd_addr      (w_rd_addr),
    .w_data         (w_data),
    .b_rd_addr      (b_rd_addr),
    .b_data         (b_data),
    .fc_o_valid     (fc_o_valid),
    .fc_o_data      (fc_o_data),
    .fc_o_idx       (fc_o_idx),
    .fc_busy        (fc_busy),
    .fc_done        (fc_done),
    .fc_class       (fc_class),
    .cap_ovr        (cap_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight / bias ROMs with one cycle of read latency.
  always @(posedge clk) begin
    w_data <= (int'(w_rd_addr) < N*ON) ? 16'(w_rom[w_rd_addr]) : 16'sd0;
    b_data <= (int'(b_rd_addr) < ON) ? 16'(b_rom[b_rd_addr]) : 16'sd0;
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int cls(input int v);
`ifdef FC_ARGMAX_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && fc_o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_idx", int'(fc_o_idx), -1);
      end else begin
        mon_r = exp_q.pop_front();
        chk("result_data", int'(fc_o_data), mon_r.data);
        chk("result_idx", int'(fc_o_idx), mon_r.idx);
        chk("result_cycle", cyc, mon_r.cyc);
      end
    end
    if (rst_n && fc_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_cycle", cyc, mon_d.cyc);
        chk("done_class", int'(fc_class), mon_d.cls);
        chk("done_busy_low", int'(fc_busy), 0);
      end
    end
  end

  task automatic write1(input int addr, input int val);
    @(posedge clk); #1;
    h_to_full_en = 1'b1;
    to_full_h_addr = 8'(addr);
    h_in = 16'(val);
    @(posedge clk); #1;
    h_to_full_en = 1'b0;
  endtask

  task automatic capture();
    res_t  r;
    done_t d;
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      h_to_full_en = 1'b1;
      to_full_h_addr = 8'(k);
      h_in = 16'(h_vec[k]);
    end
    t_last = cyc;
    for (int o = 0; o < ON; o++) begin
      r.data = exp_vals[o];
      r.idx  = o;
      r.cyc  = t_last + N + 3 + (N + 2) * o;
      exp_q.push_back(r);
    end
    d.cyc = t_last + ON * (N + 2) + 1;
    d.cls = exp_cls;
    done_q.push_back(d);
    @(posedge clk); #1;
    h_to_full_en = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!fc_done && n < 1000);
    if (!fc_done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_uniform(input int hv, input int wv, input int bstep, input int ev, input int ebstep, input int c);
    for (int k = 0; k < N; k++) h_vec[k] = hv;
    for (int i = 0; i < N*ON; i++) w_rom[i] = wv;
    for (int o = 0; o < ON; o++) begin
      b_rom[o] = o * bstep;
      exp_vals[o] = ev + o * ebstep;
    end
    exp_cls = cls(c);
  endtask

  task automatic set_single(input int h0, input int list_sel);
    for (int k = 0; k < N; k++) h_vec[k] = (k == 0) ? h0 : 0;
    for (int o = 0; o < ON; o++) begin
      b_rom[o] = 0;
      for (int k = 0; k < N; k++) w_rom[o*N + k] = 100;
      w_rom[o*N] = (list_sel == 0) ? amax_w0[o] : floor_w0[o];
      exp_vals[o] = (list_sel == 0) ? amax_w0[o] : floor_ex[o];
    end
    exp_cls = cls((list_sel == 0) ? 1 : 9);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(fc_o_valid), 0);
    chk("reset_data", int'(fc_o_data), 0);
    chk("reset_busy", int'(fc_busy), 0);
    chk("reset_done", int'(fc_done), 0);
    chk("reset_ovr", int'(cap_ovr), 0);
    chk("reset_class", int'(fc_class), 0);
    rst_n = 1'b1;

    // Basic dot product: 30 * 1.0 * 1.0 = 30.0
    set_uniform(256, 256, 0, 7680, 0, 0);
    write1(30, 777);
    chk("busy_after_oob_write", int'(fc_busy), 0);
    chk("ovr_after_oob_write", int'(cap_ovr), 0);
    capture();
    chk("busy_during_compute", int'(fc_busy), 1);
    wait_done();

    // Bias and sign, with a stale duplicate write to index 0 first
    set_uniform(256, -128, 256, -3840, 256, 9);
    write1(0, 1234);
    capture();
    wait_done();

    // Saturation high, then low, each capture starting right after fc_done
    set_uniform(32767, 32767, 0, 32767, 0, 0);
    capture();
    wait_done();
    set_uniform(32767, -32768, 0, -32768, 0, 0);
    capture();
    wait_done();
    chk("ovr_clean_before_pulse", int'(cap_ovr), 0);

    // Overrun pulse during MAC of output 3 must not disturb the results
    set_uniform(256, 256, 0, 7680, 0, 0);
    capture();
    wait_until(t_last + 1 + (N + 2) * 3 + 5);
    h_to_full_en = 1'b1;
    to_full_h_addr = 8'd0;
    h_in = 16'sd999;
    @(posedge clk); #1;
    h_to_full_en = 1'b0;
    chk("ovr_set", int'(cap_ovr), 1);
    wait_done();
    chk("ovr_sticky", int'(cap_ovr), 1);

    // Reset during MAC of output 5
    set_uniform(256, -128, 256, -3840, 256, 9);
    capture();
    wait_until(t_last + 1 + (N + 2) * 5 + 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(fc_o_valid), 0);
    chk("midrst_data", int'(fc_o_data), 0);
    chk("midrst_idx", int'(fc_o_idx), 0);
    chk("midrst_busy", int'(fc_busy), 0);
    chk("midrst_ovr", int'(cap_ovr), 0);
    chk("midrst_waddr", int'(w_rd_addr), 0);
    chk("midrst_baddr", int'(b_rd_addr), 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("post_reset_busy", int'(fc_busy), 0);

    // Argmax pattern {5,9,9,-2,...}; only h[0] is nonzero so k alignment matters
    set_single(256, 0);
    capture();
    wait_done();

    // Floor rounding on odd halves, negative and positive
    set_single(128, 1);
    capture();
    wait_done();

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
